// File: rtl/tetris_cmd_pkg.sv
// Shared encodings for the move-command scheduler: command ops, PS/2 scan codes and
// key FSM state codes, plus the scan-code to command-op lookup.
package tetris_cmd_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LEFT    = 3'd1;
  localparam logic [2:0] OP_RIGHT   = 3'd2;
  localparam logic [2:0] OP_ROTATE  = 3'd3;
  localparam logic [2:0] OP_DOWN    = 3'd4;
  localparam logic [2:0] OP_GRAVITY = 3'd5;

  localparam logic [7:0] SC_LEFT    = 8'h23;
  localparam logic [7:0] SC_RIGHT   = 8'h34;
  localparam logic [7:0] SC_ROTATE  = 8'h2D;
  localparam logic [7:0] SC_DOWN    = 8'h2B;
  localparam logic [7:0] SC_BREAK   = 8'hF0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DELAY   = 2'd1;
  localparam logic [1:0] ST_REPEAT  = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  // Unmapped scan codes return OP_NOP, which callers treat as "not a move key".
  function automatic logic [2:0] scan_to_op(input logic [7:0] code);
    case (code)
      SC_LEFT:   scan_to_op = OP_LEFT;
      SC_RIGHT:  scan_to_op = OP_RIGHT;
      SC_ROTATE: scan_to_op = OP_ROTATE;
      SC_DOWN:   scan_to_op = OP_DOWN;
      default:   scan_to_op = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Tracks press/release of the move keys and produces a one-cycle user_evt on each press
// and on each auto-repeat, together with the currently held key.
module key_repeat_fsm
  import tetris_cmd_pkg::*;
#(
  parameter int REPEAT_DELAY = 5_000_000,
  parameter int REPEAT_RATE  = 2_500_000,
  parameter int CNT_W        = 25
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_code,
  input  logic       ps2_valid,
  output logic       user_evt,
  output logic [2:0] held_key
);

  logic [1:0]       state;
  logic             brk;
  logic [CNT_W-1:0] rcnt;
  logic [2:0]       code_op;
  logic             is_break;
  logic             press;
  logic             rel_hit;
  logic             tick;

  // user_evt is combinational so the top can set its pend flag on the strobe edge itself.
  always_comb begin
    code_op  = scan_to_op(ps2_code);
    is_break = ps2_valid && (ps2_code == SC_BREAK);
    press    = ps2_valid && !is_break && !brk && (code_op != OP_NOP) &&
               ((state == ST_IDLE) || (code_op != held_key));
    rel_hit  = ps2_valid && !is_break && brk && (state != ST_IDLE) &&
               (code_op != OP_NOP) && (code_op == held_key);
    tick     = ((state == ST_DELAY)  && (rcnt == CNT_W'(REPEAT_DELAY - 1))) ||
               ((state == ST_REPEAT) && (rcnt == CNT_W'(REPEAT_RATE - 1)));
    user_evt = press || (tick && !rel_hit);
  end

  // Later assignments take priority: a release or a new press overrides the repeat timer.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      brk      <= 1'b0;
      rcnt     <= '0;
      held_key <= OP_NOP;
    end else begin
      if ((state == ST_DELAY) || (state == ST_REPEAT)) begin
        if (tick) begin
          rcnt  <= '0;
          state <= ST_REPEAT;
        end else begin
          rcnt  <= rcnt + 1'b1;
        end
      end
      if (is_break) begin
        brk <= 1'b1;
      end else if (ps2_valid) begin
        brk <= 1'b0;
      end
      if (rel_hit) begin
        state <= ST_IDLE;
        rcnt  <= '0;
      end
      if (press) begin
        held_key <= code_op;
        rcnt     <= '0;
        state    <= (code_op == OP_ROTATE) ? ST_HOLD : ST_DELAY;
      end
    end
  end

endmodule

// File: rtl/move_cmd_scheduler.sv
// Turns PS/2 key activity and a gravity timer into one-at-a-time move commands on a
// valid/ready port; gravity has priority over user moves.
module move_cmd_scheduler
  import tetris_cmd_pkg::*;
#(
  parameter int REPEAT_DELAY  = 5_000_000,
  parameter int REPEAT_RATE   = 2_500_000,
  parameter int GRAVITY_TICKS = 25_000_000,
  parameter int CNT_W         = 25
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_code,
  input  logic       ps2_valid,
  input  logic       run,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_op
);

  logic             user_evt;
  logic [2:0]       held_key;
  logic [CNT_W-1:0] gcnt;
  logic             grav_pend;
  logic             user_pend;
  logic             grav_set;
  logic             slot_free;
  logic             load_grav;
  logic             load_user;

  key_repeat_fsm #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_W        (CNT_W)
  ) u_key_fsm (
    .clock     (clock),
    .resetn    (resetn),
    .ps2_code  (ps2_code),
    .ps2_valid (ps2_valid),
    .user_evt  (user_evt),
    .held_key  (held_key)
  );

  always_comb begin
    grav_set  = run && (gcnt == CNT_W'(GRAVITY_TICKS - 1));
    slot_free = !cmd_valid || cmd_ready;
    load_grav = slot_free && run && grav_pend;
    load_user = slot_free && run && !grav_pend && user_pend;
  end

  // Pend flags are one deep; a new set in the same cycle as a load keeps the flag raised.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      gcnt      <= '0;
      grav_pend <= 1'b0;
      user_pend <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_NOP;
    end else begin
      if (run) begin
        gcnt <= grav_set ? '0 : gcnt + 1'b1;
      end
      grav_pend <= grav_set || (grav_pend && !load_grav);
      user_pend <= user_evt || (user_pend && !load_user);
      if (slot_free) begin
        cmd_valid <= load_grav || load_user;
        cmd_op    <= load_grav ? OP_GRAVITY : (load_user ? held_key : OP_NOP);
      end
    end
  end

endmodule
